// File: rtl/dispatch_queue.sv
// dispatch_queue
// In-order dispatch buffer sitting between rename and the reservation stations.
// Renamed micro-op groups are accepted all-or-nothing. Their source-ready bits are
// resolved against a physical-register busy table, so a stored entry never needs an
// RS wakeup for a producer that already wrote back. Entries leave in strict program
// order, one per ready RS write bank, with same-cycle writebacks bypassed onto the
// outgoing payload.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         synchronous flush: empties the queue and clears the busy table
//   in_valid_i      per-lane valid from rename
//   in_ready_o      group accept (room for a full group and no flush)
//   in_base_i       renamed payload per lane
//   in_oc_i         option code per lane, forwarded unchanged
//   wb_i            writeback valid per writeback port
//   wb_pdest_i      writeback physical register tags
//   wr_valid_o      RS write request per bank
//   wr_ready_i      RS bank has a free slot
//   rs_base_o       entry payload per bank ('0 when the bank is not written)
//   option_code_o   option code per bank ('0 when the bank is not written)

package dispatch_queue_pkg;

    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;

    typedef struct packed {
        logic              valid;
        logic              issued;
        logic [PREG_W-1:0] psrc0;
        logic              psrc0_valid;
        logic              psrc0_ready;
        logic [PREG_W-1:0] psrc1;
        logic              psrc1_valid;
        logic              psrc1_ready;
        logic [PREG_W-1:0] pdest;
        logic              pdest_valid;
        logic [ROB_W-1:0]  rob_idx;
        logic              position_bit;
    } RsBaseSt;

    typedef struct packed {
        logic [3:0] fu_op;
        logic [1:0] imm_sel;
        logic       use_pc;
    } OptionCodeSt;

endpackage

module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int  DISPATCH_WIDTH = 2,
    parameter int  BANK_NUM       = 2,
    parameter int  QUEUE_DEPTH    = 8,
    parameter type OPTION_CODE    = dispatch_queue_pkg::OptionCodeSt,
    parameter int  PHY_REG_NUM    = 2 ** dispatch_queue_pkg::PREG_W,
    parameter int  WB_WIDTH       = 2,
    localparam int TAG_W          = $clog2(PHY_REG_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush_i,
    input  logic [DISPATCH_WIDTH-1:0]            in_valid_i,
    output logic                                 in_ready_o,
    input  RsBaseSt [DISPATCH_WIDTH-1:0]         in_base_i,
    input  OPTION_CODE [DISPATCH_WIDTH-1:0]      in_oc_i,
    input  logic [WB_WIDTH-1:0]                  wb_i,
    input  logic [WB_WIDTH-1:0][TAG_W-1:0]       wb_pdest_i,
    output logic [BANK_NUM-1:0]                  wr_valid_o,
    input  logic [BANK_NUM-1:0]                  wr_ready_i,
    output RsBaseSt [BANK_NUM-1:0]               rs_base_o,
    output OPTION_CODE [BANK_NUM-1:0]            option_code_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    RsBaseSt    mem_base [QUEUE_DEPTH];
    OPTION_CODE mem_oc   [QUEUE_DEPTH];

    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;
    logic [PHY_REG_NUM-1:0] busy_q;
    logic [PHY_REG_NUM-1:0] busy_next;

    logic                                   enq_fire;
    logic [CNT_W-1:0]                       enq_cnt;
    RsBaseSt [DISPATCH_WIDTH-1:0]           lane_ent;
    logic [DISPATCH_WIDTH-1:0][PTR_W-1:0]   lane_slot;
    logic [DISPATCH_WIDTH-1:0]              older0;
    logic [DISPATCH_WIDTH-1:0]              older1;

    logic [CNT_W-1:0] rank;
    logic [CNT_W-1:0] deq_cnt;

    // True when any writeback this cycle targets the given physical register.
    function automatic logic wb_match(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_WIDTH; k++) begin
            if (wb_i[k] && (wb_pdest_i[k] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Free space is checked against a whole group, not just its valid lanes, so
    // rename never has to know how many lanes survive compaction.
    assign in_ready_o = ((CNT_W'(QUEUE_DEPTH) - count_q) >= CNT_W'(DISPATCH_WIDTH)) && !flush_i;

    // Lane compaction and source readiness at enqueue. A source is ready unless its
    // producer is still in flight: either marked busy, or an older valid lane of this
    // same group, whose pdest is not in the busy table yet. A same-cycle writeback
    // overrides both.
    always_comb begin
        enq_fire  = in_ready_o && (|in_valid_i);
        enq_cnt   = '0;
        lane_ent  = in_base_i;
        lane_slot = '0;
        older0    = '0;
        older1    = '0;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            for (int j = 0; j < l; j++) begin
                if (in_valid_i[j] && in_base_i[j].pdest_valid) begin
                    if (in_base_i[j].pdest == in_base_i[l].psrc0) begin
                        older0[l] = 1'b1;
                    end
                    if (in_base_i[j].pdest == in_base_i[l].psrc1) begin
                        older1[l] = 1'b1;
                    end
                end
            end
            lane_ent[l].valid       = 1'b1;
            lane_ent[l].issued      = 1'b0;
            lane_ent[l].psrc0_ready = !in_base_i[l].psrc0_valid
                                    || (!busy_q[in_base_i[l].psrc0] && !older0[l])
                                    || wb_match(in_base_i[l].psrc0);
            lane_ent[l].psrc1_ready = !in_base_i[l].psrc1_valid
                                    || (!busy_q[in_base_i[l].psrc1] && !older1[l])
                                    || wb_match(in_base_i[l].psrc1);
            lane_slot[l] = tail_q + PTR_W'(enq_cnt);
            if (in_valid_i[l]) begin
                enq_cnt = enq_cnt + 1'b1;
            end
        end
        if (!enq_fire) begin
            enq_cnt = '0;
        end
    end

    // Busy table update: writebacks clear first, then enqueued producers set, so a
    // new producer of a register wins over a stale writeback of the same tag.
    always_comb begin
        busy_next = busy_q;
        for (int k = 0; k < WB_WIDTH; k++) begin
            if (wb_i[k]) begin
                busy_next[wb_pdest_i[k]] = 1'b0;
            end
        end
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            if (enq_fire && in_valid_i[l] && in_base_i[l].pdest_valid) begin
                busy_next[in_base_i[l].pdest] = 1'b1;
            end
        end
    end

    // Dispatch: the n-th ready bank (ascending index) takes entry head+n while entries
    // remain. Stopping at the first missing entry keeps strict program order.
    always_comb begin
        rank          = '0;
        deq_cnt       = '0;
        wr_valid_o    = '0;
        rs_base_o     = '0;
        option_code_o = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (wr_ready_i[b] && !flush_i && (rank < count_q)) begin
                wr_valid_o[b]            = 1'b1;
                rs_base_o[b]             = mem_base[head_q + PTR_W'(rank)];
                rs_base_o[b].valid       = 1'b1;
                rs_base_o[b].issued      = 1'b0;
                rs_base_o[b].psrc0_ready = rs_base_o[b].psrc0_ready | wb_match(rs_base_o[b].psrc0);
                rs_base_o[b].psrc1_ready = rs_base_o[b].psrc1_ready | wb_match(rs_base_o[b].psrc1);
                option_code_o[b]         = mem_oc[head_q + PTR_W'(rank)];
                deq_cnt                  = deq_cnt + 1'b1;
            end
            if (wr_ready_i[b]) begin
                rank = rank + 1'b1;
            end
        end
    end

    // Pointers, busy table and entry storage. Stored entries are woken by writebacks
    // first; a slot being enqueued this cycle is then overwritten with its freshly
    // computed payload, which already includes the writeback bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_base[i] <= '0;
                mem_oc[i]   <= '0;
            end
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(deq_cnt);
            tail_q  <= tail_q + PTR_W'(enq_cnt);
            count_q <= count_q + enq_cnt - deq_cnt;
            busy_q  <= busy_next;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (wb_match(mem_base[i].psrc0)) begin
                    mem_base[i].psrc0_ready <= 1'b1;
                end
                if (wb_match(mem_base[i].psrc1)) begin
                    mem_base[i].psrc1_ready <= 1'b1;
                end
            end
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                if (enq_fire && in_valid_i[l]) begin
                    mem_base[lane_slot[l]] <= lane_ent[l];
                    mem_oc[lane_slot[l]]   <= in_oc_i[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue
// Directed bench for dispatch_queue. Stimulus pushes the hand-computed entries each
// bank should receive into a scoreboard; a negedge monitor pops and compares every
// RS write the DUT presents. Handshake-level expectations are checked inline.

module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush_i = 1'b0;
    logic [1:0]        in_valid_i = '0;
    logic              in_ready_o;
    RsBaseSt [1:0]     in_base_i = '0;
    OptionCodeSt [1:0] in_oc_i = '0;
    logic [1:0]        wb_i = '0;
    logic [1:0][5:0]   wb_pdest_i = '0;
    logic [1:0]        wr_valid_o;
    logic [1:0]        wr_ready_i = 2'b11;
    RsBaseSt [1:0]     rs_base_o;
    OptionCodeSt [1:0] option_code_o;

    typedef struct {
        int          bank;
        RsBaseSt     base;
        OptionCodeSt oc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    dispatch_queue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_base_i     (in_base_i),
        .in_oc_i       (in_oc_i),
        .wb_i          (wb_i),
        .wb_pdest_i    (wb_pdest_i),
        .wr_valid_o    (wr_valid_o),
        .wr_ready_i    (wr_ready_i),
        .rs_base_o     (rs_base_o),
        .option_code_o (option_code_o)
    );

    always #5 clk = ~clk;

    function automatic RsBaseSt mk(input logic [5:0] p0, input logic p0v,
                                   input logic [5:0] p1, input logic p1v,
                                   input logic [5:0] pd, input logic pdv,
                                   input logic [5:0] rob);
        RsBaseSt r;
        r              = '0;
        r.psrc0        = p0;
        r.psrc0_valid  = p0v;
        r.psrc1        = p1;
        r.psrc1_valid  = p1v;
        r.pdest        = pd;
        r.pdest_valid  = pdv;
        r.rob_idx      = rob;
        r.position_bit = rob[0];
        return r;
    endfunction

    function automatic OptionCodeSt oc_of(input logic [5:0] rob);
        OptionCodeSt o;
        o.fu_op   = rob[3:0];
        o.imm_sel = 2'b10;
        o.use_pc  = rob[4];
        return o;
    endfunction

    task automatic push_exp(input int bank, input RsBaseSt b, input logic r0, input logic r1);
        exp_t e;
        e.bank             = bank;
        e.base             = b;
        e.base.valid       = 1'b1;
        e.base.issued      = 1'b0;
        e.base.psrc0_ready = r0;
        e.base.psrc1_ready = r1;
        e.oc               = oc_of(b.rob_idx);
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [1:0] valid, input RsBaseSt b0, input RsBaseSt b1,
                                  input logic [1:0] ready, input logic [1:0] wb,
                                  input logic [5:0] t0, input logic [5:0] t1, input logic flush);
        @(posedge clk);
        #1;
        in_valid_i    = valid;
        in_base_i[0]  = b0;
        in_base_i[1]  = b1;
        in_oc_i[0]    = oc_of(b0.rob_idx);
        in_oc_i[1]    = oc_of(b1.rob_idx);
        wr_ready_i    = ready;
        wb_i          = wb;
        wb_pdest_i[0] = t0;
        wb_pdest_i[1] = t1;
        flush_i       = flush;
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every RS write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int b = 0; b < 2; b++) begin
                if (wr_valid_o[b]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_dispatch bank %0d: got base %h, expected no write",
                                 b, rs_base_o[b]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.bank != b || rs_base_o[b] !== e.base || option_code_o[b] !== e.oc) begin
                            errors++;
                            $display("[TB] FAIL dispatch_entry: got bank %0d base %h oc %h, expected bank %0d base %h oc %h",
                                     b, rs_base_o[b], option_code_o[b], e.bank, e.base, e.oc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RsBaseSt nop, a, b, c, d, e, f, g, h, i, j, x, y, z, p;
        nop = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);

        #3;
        check_output("reset_wr_valid", 32'(wr_valid_o), 32'h0);
        #9;
        rst_n = 1'b1;
        #1;
        check_output("reset_in_ready", 32'(in_ready_o), 32'h1);
        check_output("reset_empty_wr_valid", 32'(wr_valid_o), 32'h0);
        check_output("reset_rs_base", 32'(rs_base_o[0]) | 32'(rs_base_o[1]), 32'h0);
        check_output("reset_option_code", 32'(option_code_o[0]) | 32'(option_code_o[1]), 32'h0);

        // Intra-group dependency: B reads A's pdest.
        a = mk(6'd5, 1'b1, 6'd0, 1'b0, 6'd10, 1'b1, 6'd1);
        b = mk(6'd10, 1'b1, 6'd0, 1'b0, 6'd11, 1'b1, 6'd2);
        push_exp(0, a, 1'b1, 1'b1);
        push_exp(1, b, 1'b0, 1'b1);
        apply_stimulus(2'b11, a, b, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("no_passthrough", 32'(wr_valid_o), 32'h0);
        apply_stimulus(2'b00, nop, nop, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("group_dispatch", 32'(wr_valid_o), 32'h3);

        // Same-cycle writeback bypass on the outgoing entry; busy[10] then clears.
        c = mk(6'd10, 1'b1, 6'd11, 1'b1, 6'd12, 1'b1, 6'd3);
        push_exp(0, c, 1'b1, 1'b0);
        apply_stimulus(2'b01, c, nop, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        apply_stimulus(2'b00, nop, nop, 2'b01, 2'b01, 6'd10, 6'd0, 1'b0);
        check_output("bypass_dispatch", 32'(wr_valid_o), 32'h1);

        // psrc0=10 now free; psrc1=11 busy until a writeback wakes the stored entry.
        d = mk(6'd10, 1'b1, 6'd11, 1'b1, 6'd0, 1'b0, 6'd4);
        push_exp(0, d, 1'b1, 1'b1);
        apply_stimulus(2'b01, d, nop, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        apply_stimulus(2'b00, nop, nop, 2'b00, 2'b10, 6'd0, 6'd11, 1'b0);
        apply_stimulus(2'b00, nop, nop, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("wakeup_dispatch", 32'(wr_valid_o), 32'h1);

        // Only bank1 ready: head entry goes to bank1, the next waits.
        e = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5);
        f = mk(6'd12, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd6);
        push_exp(1, e, 1'b1, 1'b1);
        push_exp(0, f, 1'b0, 1'b1);
        apply_stimulus(2'b11, e, f, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        apply_stimulus(2'b00, nop, nop, 2'b10, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("bank1_only", 32'(wr_valid_o), 32'h2);
        apply_stimulus(2'b00, nop, nop, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("second_entry", 32'(wr_valid_o), 32'h1);

        // Lane 1 only, then enqueue and dispatch in the same cycle.
        g = mk(6'd30, 1'b1, 6'd0, 1'b0, 6'd30, 1'b1, 6'd7);
        h = mk(6'd12, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd8);
        push_exp(0, h, 1'b0, 1'b1);
        apply_stimulus(2'b10, g, h, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        i = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd9);
        j = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd10);
        push_exp(0, i, 1'b1, 1'b1);
        push_exp(1, j, 1'b1, 1'b1);
        apply_stimulus(2'b11, i, j, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("single_lane_count", 32'(wr_valid_o), 32'h1);
        apply_stimulus(2'b00, nop, nop, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("enq_deq_overlap", 32'(wr_valid_o), 32'h3);

        // Fill to full, probe full, drain; three times so pointers wrap.
        for (int r = 0; r < 3; r++) begin
            for (int gi = 0; gi < 4; gi++) begin
                x = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'(16 + r * 8 + gi * 2));
                y = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'(17 + r * 8 + gi * 2));
                push_exp(0, x, 1'b1, 1'b1);
                push_exp(1, y, 1'b1, 1'b1);
                apply_stimulus(2'b11, x, y, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
                check_output("fill_in_ready", 32'(in_ready_o), 32'h1);
            end
            z = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd63);
            apply_stimulus(2'b01, z, nop, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
            check_output("full_in_ready", 32'(in_ready_o), 32'h0);
            for (int dr = 0; dr < 4; dr++) begin
                apply_stimulus(2'b00, nop, nop, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
                check_output("drain_wr_valid", 32'(wr_valid_o), 32'h3);
            end
        end

        // Flush with five entries queued; pdest 20 and 12 must read not-busy after.
        apply_stimulus(2'b11, mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd40),
                       mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd20, 1'b1, 6'd41), 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        apply_stimulus(2'b11, mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd42),
                       mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd43), 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        apply_stimulus(2'b01, mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd44), nop,
                       2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        apply_stimulus(2'b00, nop, nop, 2'b11, 2'b00, 6'd0, 6'd0, 1'b1);
        check_output("flush_wr_valid", 32'(wr_valid_o), 32'h0);
        check_output("flush_in_ready", 32'(in_ready_o), 32'h0);
        apply_stimulus(2'b00, nop, nop, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("post_flush_empty", 32'(wr_valid_o), 32'h0);
        check_output("post_flush_in_ready", 32'(in_ready_o), 32'h1);
        p = mk(6'd20, 1'b1, 6'd12, 1'b1, 6'd0, 1'b0, 6'd45);
        push_exp(0, p, 1'b1, 1'b1);
        apply_stimulus(2'b01, p, nop, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        apply_stimulus(2'b00, nop, nop, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("post_flush_dispatch", 32'(wr_valid_o), 32'h1);

        // Asynchronous reset with entries queued discards them at once.
        apply_stimulus(2'b11, mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd50),
                       mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd51), 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        @(posedge clk);
        #2;
        in_valid_i = 2'b00;
        rst_n      = 1'b0;
        wr_ready_i = 2'b11;
        #1;
        check_output("async_reset_wr_valid", 32'(wr_valid_o), 32'h0);
        check_output("async_reset_in_ready", 32'(in_ready_o), 32'h1);
        #3;
        rst_n = 1'b1;
        apply_stimulus(2'b00, nop, nop, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        check_output("post_reset_empty", 32'(wr_valid_o), 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
